bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter controller using the shift-and-add-3 (double-dabble) algorithm.
- One shared add-3/shift datapath is stepped once per clock under a small FSM, instead of a wide combinational converter.
- Output digits feed bcd_to_7_seg_n directly, so the board displays the decimal value of a multi-bit binary input.
- Start/busy/done handshake allows a free-running counter or switch sampler to request conversions.

---
 rtl/bin_to_bcd_seq.sv | 123 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3 / double dabble).
// One add-3/shift step runs per clock under a two-state FSM. A conversion
// takes W cycles from the accepted start edge. bcd_vals only changes on the
// final step, so a display fed from it never shows partial scratch values.
module bin_to_bcd_seq #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] bin_in,
  output logic         busy,
  output logic         done,
  output logic [3:0]   bcd_vals [D-1:0]
);

  localparam int SW = 4 * D;           // BCD scratch width
  localparam int CW = $clog2(W + 1);   // iteration counter width

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // D digits must be able to hold the largest W-bit value.
  if (pow10(D) <= ((64'd1 << W) - 64'd1)) begin : g_bad_digit_count
    $error("bin_to_bcd_seq: D digits cannot represent 2^W-1");
  end

  typedef enum logic {
    S_IDLE,
    S_CONV
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    bin_q,   bin_d;
  logic [SW-1:0]   scr_q,   scr_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [SW-1:0]   bcd_q,   bcd_d;
  logic            done_q,  done_d;

  logic [SW-1:0]   scr_adj;
  logic [SW+W-1:0] shifted;

  // Add-3 correction: any digit >= 5 becomes >= 8 so the shift carries it.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first;
    // a path that leaves it unassigned would infer a latch.
    scr_adj = scr_q;
    for (int i = 0; i < D; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    end
  end

  // Binary MSB moves into scratch bit 0 as the combined register shifts left.
  assign shifted = {scr_adj, bin_q} << 1;

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bin_d   = bin_in;
          scr_d   = '0;
          cnt_d   = CW'(W);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        scr_d = shifted[SW+W-1:W];
        bin_d = shifted[W-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = shifted[SW+W-1:W];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      // NOTE: the result register is a handful of flops, not a memory, so
      // it is reset along with the control state to give a defined display.
      state_q <= S_IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_CONV);
  assign done = done_q;

  // Present the packed result as one 4-bit element per digit.
  always_comb begin
    for (int i = 0; i < D; i++) bcd_vals[i] = bcd_q[4*i +: 4];
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (W=8, D=3): directed vector table,
// hand-written multi-cycle sequences, exhaustive sweep and random traffic
// checked against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  localparam int W = 8;
  localparam int D = 3;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] bin_in;
  logic         busy;
  logic         done;
  logic [3:0]   bcd_vals [D-1:0];

  int tests_run = 0;
  int tests_failed = 0;

  bin_to_bcd_seq #(.W(W), .D(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_vals (bcd_vals)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] exp;  // digits as hex nibbles: 12'h255 means 2,5,5
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [11:0] digits();
    return {bcd_vals[2], bcd_vals[1], bcd_vals[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One conversion: start accepted at the next edge, bin_in scrambled while
  // busy, latency and busy length checked, result returned.
  task automatic do_conv(input logic [7:0] v, input string name, output logic [11:0] res);
    int lat;
    int busy_n;
    start  = 1'b1;
    bin_in = v;
    tick();
    start  = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      bin_in = 8'($urandom);
      tick();
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(W));
    check({name, " busy cycles"}, 32'(busy_n), 32'(W));
    check({name, " busy in done cycle"}, 32'(busy), 32'd0);
    res = digits();
  endtask

  initial begin
    logic [11:0] res;
    logic [11:0] prev;
    int k;

    vecs[0] = '{8'd255, 12'h255};
    vecs[1] = '{8'd0,   12'h000};
    vecs[2] = '{8'd99,  12'h099};
    vecs[3] = '{8'd128, 12'h128};
    vecs[4] = '{8'd10,  12'h010};
    vecs[5] = '{8'd200, 12'h200};
    vecs[6] = '{8'd7,   12'h007};
    vecs[7] = '{8'd1,   12'h001};
    vecs[8] = '{8'd9,   12'h009};
    vecs[9] = '{8'd100, 12'h100};

    // Reset then idle.
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    tick();
    tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset digits", 32'(digits()), 32'h000);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle hold", {busy, done, digits()}, 32'h0);
    end

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      do_conv(vecs[i].bin, $sformatf("vec%0d", i), res);
      check($sformatf("vec%0d digits", i), 32'(res), 32'(vecs[i].exp));
    end
    // done is a single-cycle pulse.
    tick();
    check("done one cycle", 32'(done), 32'd0);

    // Starts during a conversion are ignored.
    start  = 1'b1;
    bin_in = 8'd255;
    tick();
    start = 1'b0;
    for (k = 1; k <= 8; k++) begin
      start  = (k == 2 || k == 5);
      bin_in = 8'd7;
      tick();
      check($sformatf("ignore done@%0d", k), 32'(done), 32'(k == 8));
    end
    start = 1'b0;
    check("ignore digits", 32'(digits()), 32'h255);
    tick();
    check("ignore then idle", {busy, done}, 32'd0);

    // start held high: back-to-back conversions every W+1 cycles.
    start  = 1'b1;
    bin_in = 8'd10;
    tick();
    bin_in = 8'd200;
    for (k = 1; k <= 17; k++) begin
      if (k == 17) start = 1'b0;
      tick();
      check($sformatf("held done@%0d", k), 32'(done), 32'(k == 8 || k == 17));
      check($sformatf("held busy@%0d", k), 32'(busy), 32'(!(k == 8 || k == 17)));
      if (k == 8)  check("held first digits", 32'(digits()), 32'h010);
      if (k == 17) check("held second digits", 32'(digits()), 32'h200);
    end

    // Asynchronous reset mid-conversion discards the result.
    do_conv(8'd255, "prior", res);
    check("prior digits", 32'(res), 32'h255);
    start  = 1'b1;
    bin_in = 8'd128;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort digits", 32'(digits()), 32'h000);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("abort quiet", {busy, done, digits()}, 32'h0);
    end
    do_conv(8'd128, "after abort", res);
    check("after abort digits", 32'(res), 32'h128);

    // Exhaustive sweep against the reference model.
    for (int v = 0; v < 256; v++) begin
      do_conv(8'(v), "sweep", res);
      check($sformatf("sweep %0d", v), 32'(res), 32'(ref_bcd(v)));
    end

    // Random values with random idle gaps; result must hold while idle.
    for (int n = 0; n < 150; n++) begin
      int v;
      int gap;
      v    = int'($urandom_range(0, 255));
      gap  = int'($urandom_range(0, 3));
      prev = digits();
      for (int g = 0; g < gap; g++) begin
        bin_in = 8'($urandom);
        tick();
        check("random idle hold", 32'(digits()), 32'(prev));
      end
      do_conv(8'(v), "random", res);
      check($sformatf("random %0d", v), 32'(res), 32'(ref_bcd(v)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
